ahb_bridge_arbiter: RTL and testbench

// - Round-robin AHB arbiter sharing the single AHB slave port of the AHB-APB bridge among NUM_M requesting masters.
// - Muxes the owner's address-phase signals (Htrans/Haddr/Hwrite) and the data-phase owner's Hwdata into the bridge.
// - Returns Hreadyout to every master; Hrdata/Hresp are pass-through from the bridge.
// - Switches ownership only at transfer boundaries; fairness is bounded by MAX_HOLD.

---
 rtl/ahb_bridge_arbiter.sv | 146 ++++++++++++++
 tb/tb_ahb_bridge_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-APB bridge slave port among NUM_M masters.
// Ownership changes only at transfer boundaries; MAX_HOLD bounds how long one owner may stay.
module ahb_bridge_arbiter #(
  parameter int unsigned NUM_M    = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_M-1:0]      Hbusreq,
  input  logic [2*NUM_M-1:0]    m_Htrans,
  input  logic [32*NUM_M-1:0]   m_Haddr,
  input  logic [NUM_M-1:0]      m_Hwrite,
  input  logic [32*NUM_M-1:0]   m_Hwdata,
  output logic [NUM_M-1:0]      Hgrant,
  output logic [1:0]            Hmaster,
  output logic [1:0]            Htrans,
  output logic [31:0]           Haddr,
  output logic                  Hwrite,
  output logic [31:0]           Hwdata,
  output logic                  Hreadyin,
  input  logic                  Hreadyout
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  typedef enum logic {ARB_IDLE, ARB_OWN} state_t;

  state_t            state, nxt_state;
  logic [NUM_M-1:0]  nxt_grant, search_mask, win_oh;
  logic [1:0]        dmaster, rr_ptr, nxt_master, nxt_dmaster, nxt_rr;
  logic [1:0]        own_next, search_start, win_idx;
  logic [HW-1:0]     hold_cnt, nxt_hold, hold_inc;
  logic [1:0]        own_trans;
  logic [31:0]       own_addr;
  logic              own_write, own_req, win_found, boundary, release_bus;

  always_comb begin
    own_trans = '0;
    own_addr  = '0;
    own_write = 1'b0;
    own_req   = 1'b0;
    Hwdata    = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (Hmaster == 2'(i)) begin
        own_trans = m_Htrans[2*i +: 2];
        own_addr  = m_Haddr[32*i +: 32];
        own_write = m_Hwrite[i];
        own_req   = Hbusreq[i];
      end
      if (dmaster == 2'(i)) Hwdata = m_Hwdata[32*i +: 32];
    end
  end

  assign Htrans   = (state == ARB_OWN) ? own_trans : '0;
  assign Haddr    = (state == ARB_OWN) ? own_addr  : '0;
  assign Hwrite   = (state == ARB_OWN) ? own_write : 1'b0;
  assign Hreadyin = Hreadyout;

  assign own_next = (32'(Hmaster) == NUM_M - 1) ? '0 : Hmaster + 2'd1;

  // Rotating priority: lowest requester at or above the start index, else lowest below it.
  always_comb begin
    search_start = (state == ARB_OWN) ? own_next : rr_ptr;
    search_mask  = (state == ARB_OWN) ? (Hbusreq & ~Hgrant) : Hbusreq;
    win_found    = 1'b0;
    win_idx      = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (!win_found && search_mask[i] && (i >= 32'(search_start))) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (!win_found && search_mask[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    win_oh = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      win_oh[i] = win_found && (win_idx == 2'(i));
    end
  end

  // The hold limit counts the transfer accepted on this very edge.
  assign hold_inc    = (own_trans[1] && (hold_cnt < HW'(MAX_HOLD))) ? hold_cnt + HW'(1) : hold_cnt;
  assign boundary    = Hreadyout && (own_trans != TR_SEQ) && (own_trans != TR_BUSY);
  assign release_bus = boundary && (!own_req || ((hold_inc >= HW'(MAX_HOLD)) && win_found));

  always_comb begin
    nxt_state   = state;
    nxt_grant   = Hgrant;
    nxt_master  = Hmaster;
    nxt_rr      = rr_ptr;
    nxt_hold    = hold_cnt;
    nxt_dmaster = Hreadyout ? Hmaster : dmaster;
    case (state)
      ARB_IDLE: begin
        if (win_found) begin
          nxt_state  = ARB_OWN;
          nxt_grant  = win_oh;
          nxt_master = win_idx;
          nxt_hold   = '0;
        end
      end
      ARB_OWN: begin
        if (Hreadyout) begin
          nxt_hold = hold_inc;
          if (release_bus) begin
            nxt_rr   = own_next;
            nxt_hold = '0;
            if (win_found) begin
              nxt_grant  = win_oh;
              nxt_master = win_idx;
            end else begin
              nxt_grant = '0;
              nxt_state = ARB_IDLE;
            end
          end
        end
      end
      default: nxt_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= ARB_IDLE;
      Hgrant   <= '0;
      Hmaster  <= '0;
      dmaster  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      Hgrant   <= nxt_grant;
      Hmaster  <= nxt_master;
      dmaster  <= nxt_dmaster;
      rr_ptr   <= nxt_rr;
      hold_cnt <= nxt_hold;
    end
  end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter with two masters and MAX_HOLD=2.
module tb_ahb_bridge_arbiter;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [1:0]  Hbusreq;
  logic [3:0]  m_Htrans;
  logic [63:0] m_Haddr;
  logic [1:0]  m_Hwrite;
  logic [63:0] m_Hwdata;
  logic [1:0]  Hgrant;
  logic [1:0]  Hmaster;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;

  int checks   = 0;
  int failures = 0;

  always #5 Hclk = ~Hclk;

  ahb_bridge_arbiter #(.NUM_M(2), .MAX_HOLD(2)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq),
    .m_Htrans(m_Htrans), .m_Haddr(m_Haddr), .m_Hwrite(m_Hwrite), .m_Hwdata(m_Hwdata),
    .Hgrant(Hgrant), .Hmaster(Hmaster), .Htrans(Htrans), .Haddr(Haddr),
    .Hwrite(Hwrite), .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #2;
  endtask

  task automatic drv(input int m, input logic [1:0] t, input logic [31:0] a,
                     input logic w, input logic [31:0] d);
    if (m == 0) begin
      m_Htrans[1:0] = t; m_Haddr[31:0] = a; m_Hwrite[0] = w; m_Hwdata[31:0] = d;
    end else begin
      m_Htrans[3:2] = t; m_Haddr[63:32] = a; m_Hwrite[1] = w; m_Hwdata[63:32] = d;
    end
  endtask

  initial begin
    Hresetn = 1'b0; Hbusreq = '0; m_Htrans = '0; m_Haddr = '0;
    m_Hwrite = '0; m_Hwdata = '0; Hreadyout = 1'b1;
    tick(); tick();
    chk("rst_grant", 32'(Hgrant), 32'h0);
    chk("rst_trans", 32'(Htrans), 32'h0);
    chk("rst_master", 32'(Hmaster), 32'h0);
    Hresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_grant", 32'(Hgrant), 32'h0);
      chk("idle_trans", 32'(Htrans), 32'h0);
      chk("idle_master", 32'(Hmaster), 32'h0);
    end

    // single write from M0
    Hbusreq = 2'b01;
    drv(0, 2'b10, 32'h8000_0004, 1'b1, 32'h0);
    #1;
    chk("t2_pre_grant", 32'(Hgrant), 32'h0);
    chk("t2_pre_trans", 32'(Htrans), 32'h0);
    tick();
    chk("t2_grant", 32'(Hgrant), 32'h1);
    chk("t2_master", 32'(Hmaster), 32'h0);
    chk("t2_trans", 32'(Htrans), 32'h2);
    chk("t2_addr", Haddr, 32'h8000_0004);
    chk("t2_write", 32'(Hwrite), 32'h1);
    tick();
    Hbusreq = 2'b00;
    drv(0, 2'b00, 32'h0, 1'b0, 32'hA5A5_0001);
    #1;
    chk("t2_wdata", Hwdata, 32'hA5A5_0001);
    tick();
    chk("t2_rel_grant", 32'(Hgrant), 32'h0);
    chk("t2_rel_trans", 32'(Htrans), 32'h0);

    // both request from reset: M0 first, then M1 after M0 drops
    Hresetn = 1'b0;
    #1;
    Hresetn = 1'b1;
    Hbusreq = 2'b11;
    drv(0, 2'b10, 32'h0000_0100, 1'b1, 32'h0);
    drv(1, 2'b10, 32'h0000_0200, 1'b0, 32'h0);
    tick();
    chk("t3_grant0", 32'(Hgrant), 32'h1);
    chk("t3_addr0", Haddr, 32'h0000_0100);
    tick();
    Hbusreq = 2'b10;
    drv(0, 2'b00, 32'h0, 1'b0, 32'h0);
    tick();
    chk("t3_grant1", 32'(Hgrant), 32'h2);
    chk("t3_master1", 32'(Hmaster), 32'h1);
    chk("t3_addr1", Haddr, 32'h0000_0200);
    chk("t3_write1", 32'(Hwrite), 32'h0);
    chk("t3_rr_ptr", 32'(dut.rr_ptr), 32'h1);

    // three wait states in M1 data phase, with request dropped meanwhile
    tick();
    Hreadyout = 1'b0;
    Hbusreq = 2'b00;
    drv(1, 2'b00, 32'h0, 1'b0, 32'h1234_5678);
    #1;
    chk("t5_readyin", 32'(Hreadyin), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_wdata", Hwdata, 32'h1234_5678);
      chk("t5_grant", 32'(Hgrant), 32'h2);
      chk("t5_master", 32'(Hmaster), 32'h1);
      tick();
    end
    Hreadyout = 1'b1;
    Hbusreq = 2'b10;
    #1;
    chk("t5_wdata_done", Hwdata, 32'h1234_5678);
    chk("t5_readyin_done", 32'(Hreadyin), 32'h1);
    tick();
    chk("t5_grant_after", 32'(Hgrant), 32'h2);

    // reset while M1 owns
    drv(1, 2'b10, 32'h0000_0300, 1'b1, 32'h0);
    #1;
    chk("t6_pre_trans", 32'(Htrans), 32'h2);
    Hresetn = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(Hgrant), 32'h0);
    chk("t6_rst_trans", 32'(Htrans), 32'h0);
    chk("t6_rst_master", 32'(Hmaster), 32'h0);
    #1;
    Hresetn = 1'b1;
    Hbusreq = 2'b11;
    drv(0, 2'b10, 32'h0000_0040, 1'b1, 32'h0);
    tick();
    chk("t6_grant0", 32'(Hgrant), 32'h1);
    chk("t6_master0", 32'(Hmaster), 32'h0);
    chk("t4_beat1_addr", Haddr, 32'h0000_0040);

    // 4-beat burst from M0 with M1 waiting; MAX_HOLD must not split it
    tick();
    drv(0, 2'b11, 32'h0000_0044, 1'b1, 32'h0);
    #1;
    chk("t4_beat2_grant", 32'(Hgrant), 32'h1);
    chk("t4_beat2_trans", 32'(Htrans), 32'h3);
    chk("t4_beat2_addr", Haddr, 32'h0000_0044);
    tick();
    drv(0, 2'b11, 32'h0000_0048, 1'b1, 32'h0);
    #1;
    chk("t4_beat3_grant", 32'(Hgrant), 32'h1);
    tick();
    drv(0, 2'b11, 32'h0000_004C, 1'b1, 32'h0);
    #1;
    chk("t4_beat4_grant", 32'(Hgrant), 32'h1);
    chk("t4_beat4_addr", Haddr, 32'h0000_004C);
    tick();
    drv(0, 2'b00, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t4_after4_grant", 32'(Hgrant), 32'h1);
    tick();
    chk("t4_switch_grant", 32'(Hgrant), 32'h2);
    chk("t4_switch_master", 32'(Hmaster), 32'h1);
    chk("t4_rr_ptr", 32'(dut.rr_ptr), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
